// File: rtl/fft_spec_pkg.sv
// ---------------------------------------------------------------------------
// fft_spec_pkg
// Shared constants and types for the FFT spectrum buffer.
//   NUM_BINS_DEF / IDX_W_DEF / MAG_W_DEF : default frame geometry
//   CNT_W                                : width of the error counters
//   bin_t                                : {index, magnitude} record used for
//                                          the running, pending and published
//                                          peak registers
// ---------------------------------------------------------------------------
package fft_spec_pkg;
  localparam int NUM_BINS_DEF = 1024;
  localparam int IDX_W_DEF    = 10;
  localparam int MAG_W_DEF    = 10;
  localparam int CNT_W        = 8;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] index;
    logic [MAG_W_DEF-1:0] magnitude;
  } bin_t;
endpackage

// File: rtl/spec_dpram.sv
// ---------------------------------------------------------------------------
// spec_dpram
// Simple dual-port RAM: one synchronous write port and one registered read
// port, written so that synthesis maps it onto block RAM. The address is
// {bank, index}; the caller keeps the two ports on different banks.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data, one cycle after i_raddr
// ---------------------------------------------------------------------------
module spec_dpram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fft_spectrum_buffer.sv
// ---------------------------------------------------------------------------
// fft_spectrum_buffer
// Captures the FFT magnitude stream into a ping-pong RAM and publishes only
// complete, in-sequence frames to the display read port.
//   clk, reset (async, active-low)
//   fft_data_valid / fft_out_index / fft_out_abs : incoming bin stream
//   rd_hold      : display scanning; bank swap deferred while high
//   rd_addr      : display read address
//   rd_data      : magnitude from the display bank, 1-cycle latency
//   frame_ready  : one-cycle pulse per bank swap
//   peak_index / peak_value : peak bin (1..NUM_BINS/2-1) of displayed frame
//   overrun_cnt  : frames lost because the swap stayed deferred (saturating)
//   seq_err_cnt  : frames discarded for index discontinuity (saturating)
// Build option: define FFT_SPECTRUM_PEAK_EN to build the peak tracker;
// otherwise peak_index/peak_value are tied to 0.
// ---------------------------------------------------------------------------
module fft_spectrum_buffer
  import fft_spec_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAG_W    = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fft_data_valid,
  input  logic [IDX_W-1:0] fft_out_index,
  input  logic [MAG_W-1:0] fft_out_abs,
  input  logic             rd_hold,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [MAG_W-1:0] rd_data,
  output logic             frame_ready,
  output logic [IDX_W-1:0] peak_index,
  output logic [MAG_W-1:0] peak_value,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             r_wr_bank;
  logic [IDX_W-1:0] r_exp_idx;
  logic             r_frame_good;
  logic             r_swap_pending;
  logic             r_frame_ready;
  logic             r_rd_vld_p1;
  logic [CNT_W-1:0] r_ovr_cnt;
  logic [CNT_W-1:0] r_seq_cnt;

  logic             w_start;
  logic             w_in_seq;
  logic             w_last;
  logic             w_swap;
  logic             w_overrun;
  logic             w_seq_err;
  logic             w_wbank;
  logic [MAG_W-1:0] w_ram_q;

  assign w_start   = fft_data_valid && (fft_out_index == '0);
  assign w_in_seq  = fft_data_valid && (fft_out_index == r_exp_idx);
  assign w_last    = w_in_seq && r_frame_good && (fft_out_index == IDX_W'(NUM_BINS - 1));
  assign w_swap    = r_swap_pending && !rd_hold;
  assign w_overrun = w_start && r_swap_pending && rd_hold;
  // An index 0 is a resync, never a discontinuity; only the first bad index
  // of a good frame is counted since frame_good drops with it.
  assign w_seq_err = fft_data_valid && !w_start && r_frame_good && !w_in_seq;
  // A write in the swap cycle lands in the bank the display just released.
  assign w_wbank   = r_wr_bank ^ w_swap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank      <= 1'b0;
      r_exp_idx      <= '0;
      r_frame_good   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_frame_ready  <= 1'b0;
      r_rd_vld_p1    <= 1'b0;
      r_ovr_cnt      <= '0;
      r_seq_cnt      <= '0;
    end else begin
      r_rd_vld_p1   <= 1'b1;
      r_frame_ready <= w_swap;
      if (w_swap) r_wr_bank <= ~r_wr_bank;

      if (w_start) begin
        r_frame_good <= 1'b1;
        r_exp_idx    <= IDX_W'(1);
      end else if (fft_data_valid) begin
        if (w_in_seq) r_exp_idx    <= r_exp_idx + 1'b1;
        else          r_frame_good <= 1'b0;
      end

      if (w_last)                     r_swap_pending <= 1'b1;
      else if (w_swap || w_overrun)   r_swap_pending <= 1'b0;

      if (w_overrun) r_ovr_cnt <= sat_inc(r_ovr_cnt);
      if (w_seq_err) r_seq_cnt <= sat_inc(r_seq_cnt);
    end
  end

  spec_dpram #(
    .ADDR_W (IDX_W + 1),
    .DATA_W (MAG_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (fft_data_valid),
    .i_waddr ({w_wbank, fft_out_index}),
    .i_wdata (fft_out_abs),
    .i_raddr ({~r_wr_bank, rd_addr}),
    .o_rdata (w_ram_q)
  );

  // read stage p1: RAM output register, masked until the first clocked read
  assign rd_data     = r_rd_vld_p1 ? w_ram_q : '0;
  assign frame_ready = r_frame_ready;
  assign overrun_cnt = r_ovr_cnt;
  assign seq_err_cnt = r_seq_cnt;

`ifdef FFT_SPECTRUM_PEAK_EN
  bin_t r_run;
  bin_t r_pend;
  bin_t r_pub;
  logic w_in_band;

  // DC bin and the mirrored upper half are excluded from the search.
  assign w_in_band = (fft_out_index != '0) && (fft_out_index < IDX_W'(NUM_BINS / 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run  <= '0;
      r_pend <= '0;
      r_pub  <= '0;
    end else begin
      if (w_start)
        r_run <= '0;
      else if (fft_data_valid && w_in_band && (MAG_W_DEF'(fft_out_abs) > r_run.magnitude))
        r_run <= '{index: IDX_W_DEF'(fft_out_index), magnitude: MAG_W_DEF'(fft_out_abs)};
      if (w_last) r_pend <= r_run;
      if (w_swap) r_pub  <= r_pend;
    end
  end

  assign peak_index = IDX_W'(r_pub.index);
  assign peak_value = MAG_W'(r_pub.magnitude);
`else
  assign peak_index = '0;
  assign peak_value = '0;
`endif
endmodule

// File: tb/tb_fft_spectrum_buffer.sv
module tb_fft_spectrum_buffer;
  logic       clk;
  logic       reset;
  logic       fft_data_valid;
  logic [9:0] fft_out_index;
  logic [9:0] fft_out_abs;
  logic       rd_hold;
  logic [9:0] rd_addr;
  logic [9:0] rd_data;
  logic       frame_ready;
  logic [9:0] peak_index;
  logic [9:0] peak_value;
  logic [7:0] overrun_cnt;
  logic [7:0] seq_err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int fr_cnt = 0;

  fft_spectrum_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .fft_data_valid (fft_data_valid),
    .fft_out_index  (fft_out_index),
    .fft_out_abs    (fft_out_abs),
    .rd_hold        (rd_hold),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_ready    (frame_ready),
    .peak_index     (peak_index),
    .peak_value     (peak_value),
    .overrun_cnt    (overrun_cnt),
    .seq_err_cnt    (seq_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_ready === 1'b1) fr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int a, input int exp);
    rd_addr = a[9:0];
    tick();
    check(tag, 32'(rd_data), exp);
  endtask

  task automatic chk_peak(input string tag, input int idx, input int val);
`ifdef FFT_SPECTRUM_PEAK_EN
    check({tag, "_idx"}, 32'(peak_index), idx);
    check({tag, "_val"}, 32'(peak_value), val);
`else
    check({tag, "_idx"}, 32'(peak_index), 0);
    check({tag, "_val"}, 32'(peak_value), 0);
`endif
  endtask

  function automatic logic [9:0] mag_of(input int pat, input int i);
    logic [9:0] v;
    case (pat)
      0: v = i[9:0];
      1: v = 10'(i + 7);
      2: v = 10'(1023 - i);
      default: v = (i == 0) ? 10'd1000 : (i == 40 || i == 90) ? 10'd700 :
                   (i == 600) ? 10'd900 : 10'd10;
    endcase
    return v;
  endfunction

  task automatic send_frame(input int pat, input int first, input int last, input int skip);
    for (int i = first; i <= last; i++) begin
      if (i != skip) begin
        fft_data_valid = 1'b1;
        fft_out_index  = i[9:0];
        fft_out_abs    = mag_of(pat, i);
        tick();
      end
    end
    fft_data_valid = 1'b0;
  endtask

  initial begin
    int base;
    reset          = 1'b0;
    fft_data_valid = 1'b0;
    fft_out_index  = '0;
    fft_out_abs    = '0;
    rd_hold        = 1'b0;
    rd_addr        = '0;
    tick();
    tick();
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);
    check("rst_seq_err", 32'(seq_err_cnt), 0);
    chk_peak("rst_peak", 0, 0);
    reset = 1'b1;
    tick();

    // Full frame, display free
    send_frame(0, 0, 1023, -1);
    check("t1_no_early_ready", 32'(frame_ready), 0);
    tick();
    check("t1_ready_pulse", 32'(frame_ready), 1);
    tick();
    check("t1_ready_one_cycle", 32'(frame_ready), 0);
    check("t1_ready_count", fr_cnt, 1);
    chk_rd("t1_rd300", 300, 300);
    chk_rd("t1_rd1023", 1023, 1023);
    chk_peak("t1_peak", 511, 511);

    // Deferred swap
    rd_hold = 1'b1;
    send_frame(2, 0, 1023, -1);
    for (int k = 0; k < 50; k++) tick();
    check("t2_no_ready_held", fr_cnt, 1);
    chk_rd("t2_old_frame", 300, 300);
    rd_hold = 1'b0;
    tick();
    check("t2_ready_on_release", 32'(frame_ready), 1);
    chk_rd("t2_new_frame", 300, 723);
    chk_peak("t2_peak", 1, 1022);

    // Overrun: two frames while held
    rd_hold = 1'b1;
    send_frame(0, 0, 1023, -1);
    send_frame(1, 0, 1023, -1);
    tick();
    check("t3_overrun_cnt", 32'(overrun_cnt), 1);
    check("t3_no_ready", fr_cnt, 2);
    chk_rd("t3_display_untouched", 300, 723);
    rd_hold = 1'b0;
    tick();
    check("t3_ready", 32'(frame_ready), 1);
    chk_rd("t3_second_frame", 300, 307);
    chk_rd("t3_second_frame_0", 0, 7);
    chk_peak("t3_peak", 511, 518);

    // Sequence error: index 500 skipped
    base = fr_cnt;
    send_frame(0, 0, 1023, 500);
    tick();
    tick();
    check("t4_seq_err", 32'(seq_err_cnt), 1);
    check("t4_no_ready", fr_cnt, base);
    chk_rd("t4_display_kept", 300, 307);
    send_frame(0, 0, 1023, -1);
    tick();
    check("t4_clean_ready", 32'(frame_ready), 1);
    chk_rd("t4_clean_rd", 300, 300);
    check("t4_seq_err_stable", 32'(seq_err_cnt), 1);

    // Peak tie and exclusion
    send_frame(3, 0, 1023, -1);
    tick();
    check("t5_ready", 32'(frame_ready), 1);
    chk_peak("t5_peak", 40, 700);
    chk_rd("t5_rd600", 600, 900);
    chk_rd("t5_rd0", 0, 1000);

    // Reset mid-frame
    send_frame(0, 0, 400, -1);
    reset = 1'b0;
    tick();
    check("t6_rst_overrun", 32'(overrun_cnt), 0);
    check("t6_rst_seq_err", 32'(seq_err_cnt), 0);
    check("t6_rst_ready", 32'(frame_ready), 0);
    chk_peak("t6_rst_peak", 0, 0);
    reset = 1'b1;
    tick();
    base = fr_cnt;
    send_frame(0, 401, 1023, -1);
    tick();
    tick();
    check("t6_partial_not_published", fr_cnt, base);
    send_frame(2, 0, 1023, -1);
    tick();
    tick();
    check("t6_one_ready", fr_cnt - base, 1);
    chk_rd("t6_rd300", 300, 723);
    check("t6_overrun_zero", 32'(overrun_cnt), 0);
    check("t6_seq_err_zero", 32'(seq_err_cnt), 0);
    chk_peak("t6_peak", 1, 1022);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
